// File: rtl/ring_injector.sv
// PE-side packet source for one ring node: buffers tagged force results and
// injects them under pe_ready. Optional per-step statistics: RING_INJ_STATS_EN.
package ring_injector_pkg;
  localparam int DEST_W = 4;
  typedef logic [15:0] force_data_t;
  typedef struct packed {
    logic [DEST_W-1:0] dest_id;
    force_data_t       payload;
  } packet_t;
endpackage

// state | meaning
// IDLE  | between steps; waits for step_start, FIFO may still be emptying
// RUN   | PE producing results; pushes accepted
// DRAIN | PE finished; waits for the FIFO to empty, then pulses drained
module ring_injector
  import ring_injector_pkg::*;
#(
  parameter int HOME_CELL_ID = 0,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_start,
  input  logic              pe_done,
  input  force_data_t       force_in,
  input  logic [DEST_W-1:0] force_dest_in,
  input  logic              force_in_valid,
  output logic              force_in_ready,
  output packet_t           pe_pkt_out,
  output logic              pe_pkt_valid,
  input  logic              pe_ready,
  output logic              drained,
  output logic [CNT_W-1:0]  inj_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  self_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  packet_t         mem_q [DEPTH];
  packet_t         mem_d [DEPTH];

  logic not_empty;
  logic push;
  logic pop;
  logic clear;

  assign not_empty = (count_q != '0);

  always_comb begin
    state_d        = state_q;
    force_in_ready = 1'b0;
    drained        = 1'b0;
    clear          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        force_in_ready = (count_q != (AW+1)'(DEPTH));
        if (pe_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Empty already implies no pop this cycle.
        if (!not_empty) begin
          drained = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The ring node does not qualify pe_pkt_in with pe_ready, so valid must.
  always_comb begin
    push         = force_in_valid & force_in_ready;
    pe_pkt_valid = not_empty & pe_ready;
    pop          = pe_pkt_valid;
    pe_pkt_out   = not_empty ? mem_q[rd_ptr_q] : '0;
    mem_d        = mem_q;
    if (push) begin
      mem_d[wr_ptr_q].dest_id = force_dest_in;
      mem_d[wr_ptr_q].payload = force_in;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef RING_INJ_STATS_EN
  localparam logic [DEST_W-1:0] HOME_ID = DEST_W'(HOME_CELL_ID);

  logic [CNT_W-1:0] inj_count_q, inj_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] self_count_q, self_count_d;

  always_comb begin
    inj_count_d   = inj_count_q;
    stall_count_d = stall_count_q;
    self_count_d  = self_count_q;
    if (clear) begin
      inj_count_d   = '0;
      stall_count_d = '0;
      self_count_d  = '0;
    end else begin
      if (pop && inj_count_q != '1) inj_count_d = inj_count_q + CNT_W'(1);
      if (pop && pe_pkt_out.dest_id == HOME_ID && self_count_q != '1)
        self_count_d = self_count_q + CNT_W'(1);
      if (not_empty && !pe_ready && stall_count_q != '1)
        stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_count_q   <= '0;
      stall_count_q <= '0;
      self_count_q  <= '0;
    end else begin
      inj_count_q   <= inj_count_d;
      stall_count_q <= stall_count_d;
      self_count_q  <= self_count_d;
    end
  end

  assign inj_count   = inj_count_q;
  assign stall_count = stall_count_q;
  assign self_count  = self_count_q;
`else
  assign inj_count   = '0;
  assign stall_count = '0;
  assign self_count  = '0;
`endif

endmodule

// File: tb/tb_ring_injector.sv
// Scoreboard bench for ring_injector: a negedge model predicts FSM, FIFO
// contents, flow control and statistics; directed steps drive the stimulus.
module tb_ring_injector;
  import ring_injector_pkg::*;

`ifdef RING_INJ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int HOME  = 5;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              step_start;
  logic              pe_done;
  force_data_t       force_in;
  logic [DEST_W-1:0] force_dest_in;
  logic              force_in_valid;
  logic              force_in_ready;
  packet_t           pe_pkt_out;
  logic              pe_pkt_valid;
  logic              pe_ready;
  logic              drained;
  logic [15:0]       inj_count;
  logic [15:0]       stall_count;
  logic [15:0]       self_count;

  ring_injector #(.HOME_CELL_ID(HOME), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .step_start(step_start), .pe_done(pe_done),
    .force_in(force_in), .force_dest_in(force_dest_in),
    .force_in_valid(force_in_valid), .force_in_ready(force_in_ready),
    .pe_pkt_out(pe_pkt_out), .pe_pkt_valid(pe_pkt_valid), .pe_ready(pe_ready),
    .drained(drained), .inj_count(inj_count), .stall_count(stall_count),
    .self_count(self_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced once per cycle at the negedge.
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  mstate_t     m_state = M_IDLE;
  packet_t     exp_q[$];
  logic [15:0] m_inj, m_stall, m_self;
  int          sz;
  bit          exp_pop, exp_rdy;
  packet_t     head;

  always @(negedge clk) begin
    if (rst) begin
      m_state = M_IDLE;
      exp_q.delete();
      m_inj = 0; m_stall = 0; m_self = 0;
    end else begin
      sz      = exp_q.size();
      exp_pop = (sz != 0) && pe_ready;
      exp_rdy = (m_state == M_RUN) && (sz != DEPTH);
      head    = (sz != 0) ? exp_q[0] : '0;
      check("valid", pe_pkt_valid, exp_pop);
      check("ready", force_in_ready, exp_rdy);
      check("drained", drained, (m_state == M_DRAIN) && (sz == 0));
      check("pkt", pe_pkt_out, head);
      check("inj_cnt", inj_count, STATS ? m_inj : 16'd0);
      check("stall_cnt", stall_count, STATS ? m_stall : 16'd0);
      check("self_cnt", self_count, STATS ? m_self : 16'd0);
      if (m_state == M_IDLE && step_start) begin
        m_inj = 0; m_stall = 0; m_self = 0;
      end else begin
        if (exp_pop && m_inj != 16'hFFFF) m_inj++;
        if (exp_pop && head.dest_id == DEST_W'(HOME) && m_self != 16'hFFFF) m_self++;
        if (sz != 0 && !pe_ready && m_stall != 16'hFFFF) m_stall++;
      end
      if (exp_pop) void'(exp_q.pop_front());
      if (force_in_valid && exp_rdy) exp_q.push_back('{dest_id: force_dest_in, payload: force_in});
      case (m_state)
        M_IDLE:  if (step_start) m_state = M_RUN;
        M_RUN:   if (pe_done) m_state = M_DRAIN;
        M_DRAIN: if (sz == 0) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step_start = 1'b1; tick(); step_start = 1'b0;
  endtask

  task automatic pulse_done();
    pe_done = 1'b1; tick(); pe_done = 1'b0;
  endtask

  task automatic push_one(input logic [DEST_W-1:0] d, input logic [15:0] p);
    int n = 0;
    force_dest_in  = d;
    force_in       = p;
    force_in_valid = 1'b1;
    while (!force_in_ready && n < 50) begin tick(); n++; end
    check("push_to", force_in_ready, 1'b1);
    tick();
    force_in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (!drained && n < 60) begin tick(); n++; end
    check("drain_to", drained, 1'b1);
  endtask

  initial begin
    rst = 1'b1; step_start = 0; pe_done = 0; force_in = 0; force_dest_in = 0;
    force_in_valid = 0; pe_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", force_in_ready, 1'b0);
    check("rst_valid", pe_pkt_valid, 1'b0);
    check("rst_drained", drained, 1'b0);
    check("rst_pkt", pe_pkt_out, 20'h0);
    check("rst_inj", inj_count, 16'd0);
    tick();

    // Three results to dest 2, streaming straight through.
    pulse_step();
    for (int i = 0; i < 3; i++) begin
      push_one(4'd2, 16'hA000 + 16'(i));
      check("lat_valid", pe_pkt_valid, 1'b1);
      check("lat_pkt", pe_pkt_out, {4'd2, 16'hA000 + 16'(i)});
    end
    pulse_done();
    wait_drained();
    check("t1_inj", inj_count, STATS ? 16'd3 : 16'd0);
    tick();
    check("t1_pulse", drained, 1'b0);
    repeat (2) tick();

    // Backpressure: fill the FIFO with pe_ready low, then try two more.
    pulse_step();
    pe_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_one(4'(i), 16'hB000 + 16'(i));
    force_in_valid = 1'b1; force_in = 16'hBEEF; force_dest_in = 4'd9;
    for (int i = 0; i < 3; i++) begin
      check("full_ready", force_in_ready, 1'b0);
      check("full_valid", pe_pkt_valid, 1'b0);
      tick();
    end
    force_in_valid = 1'b0;
    check("t2_stall", stall_count, STATS ? 16'd10 : 16'd0);
    pulse_done();
    pe_ready = 1'b1;
    wait_drained();
    repeat (2) tick();

    // pe_ready toggling with four queued.
    pulse_step();
    pe_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(4'(i + 1), 16'hC000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      pe_ready = (i % 2 == 0);
      tick();
    end
    pe_ready = 1'b1;
    check("t3_empty", pe_pkt_valid, 1'b0);
    pulse_done();
    wait_drained();
    repeat (2) tick();

    // Self-addressed statistic; spurious step_start in RUN and pe_done in IDLE.
    pulse_step();
    push_one(4'(HOME), 16'hD000);
    pulse_step();
    push_one(4'd3, 16'hD001);
    push_one(4'(HOME), 16'hD002);
    push_one(4'd7, 16'hD003);
    pulse_done();
    wait_drained();
    check("t4_self", self_count, STATS ? 16'd2 : 16'd0);
    check("t4_inj", inj_count, STATS ? 16'd4 : 16'd0);
    tick();
    pulse_done();
    check("t4_idle_ready", force_in_ready, 1'b0);
    check("t4_keep_inj", inj_count, STATS ? 16'd4 : 16'd0);
    repeat (2) tick();

    // Reset in DRAIN with five entries queued.
    pulse_step();
    pe_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(4'(i + 8), 16'hE000 + 16'(i));
    pulse_done();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    pe_ready = 1'b1;
    check("rst_mid_valid", pe_pkt_valid, 1'b0);
    check("rst_mid_drained", drained, 1'b0);
    check("rst_mid_ready", force_in_ready, 1'b0);
    check("rst_mid_stall", stall_count, 16'd0);
    repeat (3) tick();

    // A fresh step after reset still works end to end.
    pulse_step();
    push_one(4'(HOME), 16'hF00D);
    pulse_done();
    wait_drained();
    check("t6_inj", inj_count, STATS ? 16'd1 : 16'd0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ring_injector.md
# ring_injector

PE-side packet source for one ring node. Accepts force results tagged with a destination cell ID from the local short-range force PE, buffers them in a FIFO, and injects them as `packet_t` into the ring node's PE port under that node's `pe_ready` flow control. A per-time-step FSM gates acceptance and reports when every buffered packet has left for the ring.

## Interface

Parameters:
- `HOME_CELL_ID`, 0: cell ID of the attached ring node. Used only for the optional self-addressed statistic.
- `DEPTH`, 8: FIFO entries. Must be a power of 2 and at least 2.
- `CNT_W`, 16: width of the statistics counters.

Ports (clock and reset first):
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high; clock clk
- `step_start`  in  1  one-cycle pulse that opens a time step
- `pe_done`  in  1  one-cycle pulse: the PE has produced its last result for the step
- `force_in`  in  force_data_t  force payload from the PE
- `force_dest_in`  in  width of `packet_t.dest_id`  destination cell ID
- `force_in_valid`  in  1  PE result valid
- `force_in_ready`  out  1  injector can accept a PE result
- `pe_pkt_out`  out  packet_t  packet to the ring node's `pe_pkt_in`
- `pe_pkt_valid`  out  1  to the ring node's `pe_pkt_valid`
- `pe_ready`  in  1  from the ring node's `pe_ready`
- `drained`  out  1  one-cycle pulse when the step's FIFO has fully emptied
- `inj_count`  out  CNT_W  packets injected in the current step
- `stall_count`  out  CNT_W  stall cycles in the current step
- `self_count`  out  CNT_W  injected packets whose `dest_id == HOME_CELL_ID`

## Operation

- FSM states and transitions:
  - IDLE: `step_start` moves to RUN and clears all counters.
  - RUN: `pe_done` moves to DRAIN.
  - DRAIN: when the FIFO is empty and no pop occurs this cycle, pulse `drained` and move to IDLE.
- `step_start` is ignored outside IDLE. `pe_done` is ignored outside RUN.
- Accept rule: `force_in_ready = (state == RUN) & (count != DEPTH)`. A push occurs when `force_in_valid & force_in_ready`. The written entry is `{dest_id: force_dest_in, payload: force_in}`.
- A result presented in the same cycle as `pe_done` is still accepted if the FIFO has space.
- Injection rule: `pe_pkt_valid = fifo_not_empty & pe_ready`. Valid is never high while `pe_ready` is low, because the ring node forwards `pe_pkt_in` without qualifying it by `pe_ready`.
- A pop occurs on every cycle where `pe_pkt_valid` is high.
- `pe_pkt_out` is the FIFO head when non-empty, and 0 when empty.
- Simultaneous push and pop: both happen and count is unchanged. A push when full is impossible because ready is low.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is `$clog2(DEPTH)+1` bits.
- Injection continues in every state, including IDLE, until the FIFO is empty.

## Timing

- Reset values:
  - state is IDLE.
  - FIFO is empty.
  - `force_in_ready`, `pe_pkt_valid` and `drained` are 0.
  - `pe_pkt_out` is 0.
  - All counters are 0.
- A push at edge N makes the entry visible on `pe_pkt_out`/`pe_pkt_valid` in cycle N+1, provided `pe_ready` is high.
- Throughput is one packet per cycle in each direction.
- `pe_ready` is used combinationally into `pe_pkt_valid`. There is no other combinational input-to-output path except `force_in_ready` from state and count.
- `drained` asserts the cycle after the last pop at the earliest.
- Reset mid-step discards the FIFO contents and the counters.

## Configuration

- `RING_INJ_STATS_EN` defined:
  - `inj_count` increments on each pop.
  - `stall_count` increments on each cycle with FIFO non-empty and `pe_ready` low.
  - `self_count` increments on each pop whose `dest_id == HOME_CELL_ID`.
  - All three counters saturate at `2^CNT_W-1` and clear on `step_start` in IDLE.
- `RING_INJ_STATS_EN` undefined: the three count outputs are tied to 0 and no counter registers exist.

## Test plan

- Reset, `step_start`, then 3 results to dest 2 with `pe_ready=1` -> 3 packets appear on consecutive cycles one cycle after each push; `pe_done` then gives `drained` a 1-cycle pulse and `inj_count=3`.
- `DEPTH=8`, hold `pe_ready=0`, push 10 results -> `force_in_ready` drops after the 8th, `pe_pkt_valid` stays 0, and `stall_count` counts every cycle while the FIFO is non-empty.
- Toggle `pe_ready` 1,0,1,0 with 4 queued -> a pop occurs only in cycles with `pe_ready=1`, and the order matches push order.
- Push 2 with `dest_id=HOME_CELL_ID` and 2 with other IDs -> `self_count=2`, `inj_count=4` (STATS_EN build); all three counts read 0 in the non-STATS build.
- Assert `rst` with 5 entries queued in DRAIN -> the next cycle shows `pe_pkt_valid=0`, state IDLE, and no `drained` pulse.
- `step_start` pulsed during RUN, and `pe_done` pulsed in IDLE -> no state change and no counter clear.
